// File: rtl/sb_tx_serializer_pkg.sv
// Shared sideband message type and serializer constants, also used by the RX deserializer.
package sb_tx_serializer_pkg;

  localparam int unsigned SB_PKT_W     = 64;
  localparam int unsigned SB_GAP_UI    = 32;
  localparam int unsigned SB_UI_CYCLES = 2;

  typedef struct packed {
    logic [31:0] msg_hi;
    logic [31:0] msg_lo;
  } SB_msg_t;

endpackage

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: accepts one SB_msg_t per handshake, shifts it out LSB-first
// with a UI-centred forwarded clock, then holds both pins low for a fixed idle gap.
module sb_tx_serializer
  import sb_tx_serializer_pkg::*;
#(
  parameter int unsigned PKT_W     = SB_PKT_W,
  parameter int unsigned UI_CYCLES = SB_UI_CYCLES,
  parameter int unsigned GAP_UI    = SB_GAP_UI
) (
  input  logic    clk_800MHz,
  input  logic    reset,
  input  logic    enable_i,
  input  SB_msg_t TX_msg_i,
  input  logic    TX_msg_valid_i,
  output logic    TX_msg_valid_ack_o,
  output logic    SB_clkPin_TX_o,
  output logic    SB_dataPin_TX_o,
  output logic    busy_o,
  output logic    pkt_sent_o
);

  localparam int unsigned UI_W  = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;
  localparam int unsigned BIT_W = (PKT_W > 1) ? $clog2(PKT_W) : 1;
  localparam int unsigned GAP_W = (GAP_UI > 1) ? $clog2(GAP_UI) : 1;

  typedef enum logic [1:0] {
    SBTX_IDLE,
    SBTX_SHIFT,
    SBTX_GAP
  } sbtx_state_e;

  sbtx_state_e        state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [UI_W-1:0]    ui_cnt_q, ui_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               ack_q, ack_d;
  logic               clk_pin_q, clk_pin_d;
  logic               data_pin_q, data_pin_d;
  logic               busy_q, busy_d;
  logic               sent_q, sent_d;

  logic ui_last, bit_last, gap_last;

  assign ui_last  = (ui_cnt_q == UI_W'(UI_CYCLES - 1));
  assign bit_last = (bit_cnt_q == BIT_W'(PKT_W - 1));
  assign gap_last = (gap_cnt_q == GAP_W'(GAP_UI - 1));

  // Next state and counters; outputs are derived from the next-state values so they register cleanly.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    ui_cnt_d  = ui_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ack_d     = 1'b0;

    unique case (state_q)
      SBTX_IDLE: begin
        if (enable_i && TX_msg_valid_i) begin
          state_d   = SBTX_SHIFT;
          shreg_d   = PKT_W'(TX_msg_i);
          ui_cnt_d  = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          ack_d     = 1'b1;
        end
      end
      SBTX_SHIFT: begin
        if (!enable_i) begin
          state_d   = SBTX_IDLE;
          shreg_d   = '0;
          ui_cnt_d  = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (ui_last) begin
          ui_cnt_d = '0;
          shreg_d  = shreg_q >> 1;
          if (bit_last) begin
            state_d   = SBTX_GAP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          ui_cnt_d = ui_cnt_q + UI_W'(1);
        end
      end
      SBTX_GAP: begin
        if (!enable_i) begin
          state_d   = SBTX_IDLE;
          shreg_d   = '0;
          ui_cnt_d  = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else if (ui_last) begin
          ui_cnt_d = '0;
          if (gap_last) begin
            state_d   = SBTX_IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end else begin
          ui_cnt_d = ui_cnt_q + UI_W'(1);
        end
      end
      default: begin
        state_d = SBTX_IDLE;
      end
    endcase

    data_pin_d = (state_d == SBTX_SHIFT) && shreg_d[0];
    clk_pin_d  = (state_d == SBTX_SHIFT) && (ui_cnt_d >= UI_W'(UI_CYCLES / 2));
    busy_d     = (state_d != SBTX_IDLE);
    sent_d     = (state_d == SBTX_GAP) && (gap_cnt_d == GAP_W'(GAP_UI - 1))
                 && (ui_cnt_d == UI_W'(UI_CYCLES - 1));
  end

  always_ff @(posedge clk_800MHz) begin
    if (reset) begin
      state_q    <= SBTX_IDLE;
      shreg_q    <= '0;
      ui_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= 1'b0;
      clk_pin_q  <= 1'b0;
      data_pin_q <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      ui_cnt_q   <= ui_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      clk_pin_q  <= clk_pin_d;
      data_pin_q <= data_pin_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  assign TX_msg_valid_ack_o = ack_q;
  assign SB_clkPin_TX_o     = clk_pin_q;
  assign SB_dataPin_TX_o    = data_pin_q;
  assign busy_o             = busy_q;
  assign pkt_sent_o         = sent_q;

endmodule
